// File: rtl/radio_txrx_sequencer_pkg.sv
// Shared types and default timing constants for the radio Tx/Rx mode sequencer.
package radio_txrx_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_WARM,
        ST_TX_RAMP,
        ST_TX_ON,
        ST_TX_DOWN,
        ST_RX_HP,
        ST_RX_ON,
        ST_GUARD
    } seq_state_e;

    localparam int unsigned DEF_TX_PA_DLY     = 40;
    localparam int unsigned DEF_GAIN_STEP_CYC = 4;
    localparam int unsigned DEF_TX_OFF_DLY    = 8;
    localparam int unsigned DEF_RXHP_CYC      = 100;
    localparam int unsigned DEF_GUARD_CYC     = 16;
    localparam int unsigned DEF_CNT_W         = 12;

    localparam int unsigned GAIN_W = 6;
    localparam int unsigned ANT_W  = 2;

endpackage

// File: rtl/seq_delay_counter.sv
// Loadable saturating down-counter; done_c is high while the count is zero.
module seq_delay_counter #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/radio_txrx_sequencer.sv
// Arbitrates Tx/Rx requests and sequences TxEn/PA/gain/RxEn/RxHP with a guard gap
// between modes. All outputs are registered from the next-state decode.
module radio_txrx_sequencer
    import radio_txrx_sequencer_pkg::*;
#(
    parameter int unsigned TX_PA_DLY     = DEF_TX_PA_DLY,
    parameter int unsigned GAIN_STEP_CYC = DEF_GAIN_STEP_CYC,
    parameter int unsigned TX_OFF_DLY    = DEF_TX_OFF_DLY,
    parameter int unsigned RXHP_CYC      = DEF_RXHP_CYC,
    parameter int unsigned GUARD_CYC     = DEF_GUARD_CYC,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic              controller_logic_clk,
    input  logic              controller_reset_n,
    input  logic              tx_req,
    input  logic              rx_req,
    input  logic              band_5g,
    input  logic [ANT_W-1:0]  ant_sel,
    input  logic [GAIN_W-1:0] tx_gain_target,
    output logic              seq_TxEn,
    output logic              seq_RxEn,
    output logic              seq_RxHP,
    output logic              seq_24PA,
    output logic              seq_5PA,
    output logic [ANT_W-1:0]  seq_ANTSW,
    output logic [GAIN_W-1:0] seq_Tx_gain,
    output logic              seq_TxStart,
    output logic              tx_active,
    output logic              rx_active,
    output logic              busy
);

    seq_state_e        state_q, state_d;
    logic              band_q;
    logic [GAIN_W-1:0] target_q;
    logic [GAIN_W-1:0] gain_d;
    logic              latch_c, tx_start_d, pa_on_c;
    logic              cnt_load_c, cnt_done_c;
    logic [CNT_W-1:0]  cnt_val_c;

    seq_delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk      (controller_logic_clk),
        .rst_n    (controller_reset_n),
        .load     (cnt_load_c),
        .load_val (cnt_val_c),
        .done_c   (cnt_done_c)
    );

    always_ff @(posedge controller_logic_clk or negedge controller_reset_n) begin
        if (!controller_reset_n) begin
            state_q     <= ST_IDLE;
            band_q      <= 1'b0;
            target_q    <= '0;
            seq_ANTSW   <= '0;
            seq_TxEn    <= 1'b0;
            seq_RxEn    <= 1'b0;
            seq_RxHP    <= 1'b0;
            seq_24PA    <= 1'b0;
            seq_5PA     <= 1'b0;
            seq_Tx_gain <= '0;
            seq_TxStart <= 1'b0;
            tx_active   <= 1'b0;
            rx_active   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_c) begin
                band_q    <= band_5g;
                target_q  <= tx_gain_target;
                seq_ANTSW <= ant_sel;
            end
            seq_TxEn    <= state_d inside {ST_TX_WARM, ST_TX_RAMP, ST_TX_ON, ST_TX_DOWN};
            seq_RxEn    <= state_d inside {ST_RX_HP, ST_RX_ON};
            seq_RxHP    <= (state_d == ST_RX_HP);
            seq_24PA    <= pa_on_c & ~band_q;
            seq_5PA     <= pa_on_c & band_q;
            seq_Tx_gain <= gain_d;
            seq_TxStart <= tx_start_d;
            tx_active   <= (state_d == ST_TX_ON);
            rx_active   <= (state_d == ST_RX_ON);
            busy        <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d    = state_q;
        gain_d     = '0;
        latch_c    = 1'b0;
        tx_start_d = 1'b0;
        cnt_load_c = 1'b0;
        cnt_val_c  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_req) begin
                    state_d = ST_TX_WARM;
                    latch_c = 1'b1;
                end else if (rx_req) begin
                    state_d = ST_RX_HP;
                    latch_c = 1'b1;
                end
            end
            ST_TX_WARM: begin
                if (!tx_req)         state_d = ST_TX_DOWN;
                else if (cnt_done_c) state_d = ST_TX_RAMP;
            end
            ST_TX_RAMP: begin
                gain_d = seq_Tx_gain;
                if (!tx_req) begin
                    state_d = ST_TX_DOWN;
                    gain_d  = '0;
                end else if (seq_Tx_gain == target_q) begin
                    state_d    = ST_TX_ON;
                    tx_start_d = 1'b1;
                end else if (cnt_done_c) begin
                    // Step the gain; the final step lands directly in TX_ON.
                    gain_d     = GAIN_W'(seq_Tx_gain + GAIN_W'(1));
                    cnt_load_c = 1'b1;
                    cnt_val_c  = CNT_W'(GAIN_STEP_CYC - 1);
                    if (gain_d == target_q) begin
                        state_d    = ST_TX_ON;
                        tx_start_d = 1'b1;
                    end
                end
            end
            ST_TX_ON: begin
                if (!tx_req) state_d = ST_TX_DOWN;
                else         gain_d  = target_q;
            end
            ST_TX_DOWN: if (cnt_done_c) state_d = ST_GUARD;
            ST_RX_HP: begin
                if (!rx_req)         state_d = ST_GUARD;
                else if (cnt_done_c) state_d = ST_RX_ON;
            end
            ST_RX_ON: if (!rx_req)   state_d = ST_GUARD;
            ST_GUARD: if (cnt_done_c) state_d = ST_IDLE;
        endcase

        // Every state entry reloads the shared delay counter.
        if (state_d != state_q) begin
            cnt_load_c = 1'b1;
            unique case (state_d)
                ST_TX_WARM: cnt_val_c = CNT_W'(TX_PA_DLY - 1);
                ST_TX_RAMP: cnt_val_c = CNT_W'(GAIN_STEP_CYC - 1);
                ST_TX_DOWN: cnt_val_c = CNT_W'(TX_OFF_DLY - 1);
                ST_RX_HP:   cnt_val_c = CNT_W'(RXHP_CYC - 1);
                ST_GUARD:   cnt_val_c = CNT_W'(GUARD_CYC - 1);
                default:    cnt_val_c = '0;
            endcase
        end

        pa_on_c = state_d inside {ST_TX_RAMP, ST_TX_ON};
    end

endmodule

// File: tb/tb_radio_txrx_sequencer.sv
// Directed bench: stimulus pushes expected output transitions (cycle + value);
// a monitor pops and compares on every observed change of the output bundle.
module tb_radio_txrx_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_req = 1'b0, rx_req = 1'b0, band_5g = 1'b0;
    logic [1:0] ant_sel = 2'd0;
    logic [5:0] tx_gain_target = 6'd0;
    logic       seq_TxEn, seq_RxEn, seq_RxHP, seq_24PA, seq_5PA;
    logic [1:0] seq_ANTSW;
    logic [5:0] seq_Tx_gain;
    logic       seq_TxStart, tx_active, rx_active, busy;

    radio_txrx_sequencer #(
        .TX_PA_DLY(4), .GAIN_STEP_CYC(2), .TX_OFF_DLY(3),
        .RXHP_CYC(5), .GUARD_CYC(4), .CNT_W(12)
    ) dut (
        .controller_logic_clk(clk),
        .controller_reset_n(rst_n),
        .tx_req(tx_req),
        .rx_req(rx_req),
        .band_5g(band_5g),
        .ant_sel(ant_sel),
        .tx_gain_target(tx_gain_target),
        .seq_TxEn(seq_TxEn),
        .seq_RxEn(seq_RxEn),
        .seq_RxHP(seq_RxHP),
        .seq_24PA(seq_24PA),
        .seq_5PA(seq_5PA),
        .seq_ANTSW(seq_ANTSW),
        .seq_Tx_gain(seq_Tx_gain),
        .seq_TxStart(seq_TxStart),
        .tx_active(tx_active),
        .rx_active(rx_active),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       te, re, hp, p24, p5;
        logic [1:0] ant;
        logic [5:0] gain;
        logic       ts, ta, ra, bsy;
    } obs_t;

    typedef struct {
        int    cyc;
        obs_t  v;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    obs_t cur, prev;
    bit   seen = 1'b0;
    exp_t e_m;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic te, re, hp, p24, p5, input logic [1:0] a,
                                input logic [5:0] g, input logic ts, ta, ra, b);
        return {te, re, hp, p24, p5, a, g, ts, ta, ra, b};
    endfunction

    task automatic push(input int c, input string n, input obs_t v);
        exp_t e;
        e.cyc = c; e.v = v; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic go_at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every change of the output bundle must match the next expected transition.
    always @(negedge clk) begin
        cur = {seq_TxEn, seq_RxEn, seq_RxHP, seq_24PA, seq_5PA, seq_ANTSW,
               seq_Tx_gain, seq_TxStart, tx_active, rx_active, busy};
        if (!seen || cur !== prev) begin
            seen = 1'b1;
            prev = cur;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: cycle %0d outputs %h", cyc, cur);
            end else begin
                e_m = exp_q.pop_front();
                if (e_m.cyc != cyc || e_m.v !== cur) begin
                    errors++;
                    $display("FAIL %s: cycle %0d (expected %0d) outputs %h (expected %h)",
                             e_m.name, cyc, e_m.cyc, cur, e_m.v);
                end
            end
        end
    end

    initial begin
        push(1, "reset", mk(0,0,0,0,0,2'd0,6'd0,0,0,0,0));
        #1 rst_n = 1'b0;
        go_at(2);
        rst_n = 1'b1;

        // Tx ramp to gain 3 on the 5 GHz PA; input changes mid-mode are ignored.
        go_at(3);
        tx_req = 1'b1; band_5g = 1'b1; ant_sel = 2'd2; tx_gain_target = 6'd3;
        push(4,  "s1_warm",   mk(1,0,0,0,0,2'd2,6'd0,0,0,0,1));
        push(8,  "s1_pa",     mk(1,0,0,0,1,2'd2,6'd0,0,0,0,1));
        push(10, "s1_gain1",  mk(1,0,0,0,1,2'd2,6'd1,0,0,0,1));
        push(12, "s1_gain2",  mk(1,0,0,0,1,2'd2,6'd2,0,0,0,1));
        push(14, "s1_txstart",mk(1,0,0,0,1,2'd2,6'd3,1,1,0,1));
        push(15, "s1_on",     mk(1,0,0,0,1,2'd2,6'd3,0,1,0,1));
        go_at(6);
        band_5g = 1'b0; ant_sel = 2'd1; tx_gain_target = 6'd7;
        go_at(18);
        tx_req = 1'b0;
        push(19, "s1_down",   mk(1,0,0,0,0,2'd2,6'd0,0,0,0,1));
        push(22, "s1_guard",  mk(0,0,0,0,0,2'd2,6'd0,0,0,0,1));
        push(26, "s1_idle",   mk(0,0,0,0,0,2'd2,6'd0,0,0,0,0));

        // Both requests: Tx wins, Rx waits until the guard completes.
        go_at(28);
        tx_req = 1'b1; rx_req = 1'b1; band_5g = 1'b0; ant_sel = 2'd1; tx_gain_target = 6'd1;
        push(29, "s2_warm",   mk(1,0,0,0,0,2'd1,6'd0,0,0,0,1));
        push(33, "s2_pa24",   mk(1,0,0,1,0,2'd1,6'd0,0,0,0,1));
        push(35, "s2_txstart",mk(1,0,0,1,0,2'd1,6'd1,1,1,0,1));
        push(36, "s2_on",     mk(1,0,0,1,0,2'd1,6'd1,0,1,0,1));
        go_at(37);
        tx_req = 1'b0;
        push(38, "s2_down",   mk(1,0,0,0,0,2'd1,6'd0,0,0,0,1));
        push(41, "s2_guard",  mk(0,0,0,0,0,2'd1,6'd0,0,0,0,1));
        push(45, "s2_idle",   mk(0,0,0,0,0,2'd1,6'd0,0,0,0,0));
        push(46, "s2_rxhp",   mk(0,1,1,0,0,2'd3,6'd0,0,0,0,1));
        push(51, "s2_rxon",   mk(0,1,0,0,0,2'd3,6'd0,0,0,1,1));
        go_at(42);
        ant_sel = 2'd3;
        go_at(53);
        rx_req = 1'b0;
        push(54, "s2_rxguard",mk(0,0,0,0,0,2'd3,6'd0,0,0,0,1));
        push(58, "s2_rxidle", mk(0,0,0,0,0,2'd3,6'd0,0,0,0,0));

        // Abort during the ramp at gain 2: TxStart must never appear.
        go_at(60);
        tx_req = 1'b1; band_5g = 1'b1; ant_sel = 2'd0; tx_gain_target = 6'd5;
        push(61, "s3_warm",   mk(1,0,0,0,0,2'd0,6'd0,0,0,0,1));
        push(65, "s3_pa",     mk(1,0,0,0,1,2'd0,6'd0,0,0,0,1));
        push(67, "s3_gain1",  mk(1,0,0,0,1,2'd0,6'd1,0,0,0,1));
        push(69, "s3_gain2",  mk(1,0,0,0,1,2'd0,6'd2,0,0,0,1));
        go_at(69);
        tx_req = 1'b0;
        push(70, "s3_down",   mk(1,0,0,0,0,2'd0,6'd0,0,0,0,1));
        push(73, "s3_guard",  mk(0,0,0,0,0,2'd0,6'd0,0,0,0,1));
        push(77, "s3_idle",   mk(0,0,0,0,0,2'd0,6'd0,0,0,0,0));

        // Target 0, then asynchronous reset while in TX_ON.
        go_at(80);
        tx_req = 1'b1; band_5g = 1'b0; ant_sel = 2'd1; tx_gain_target = 6'd0;
        push(81, "s4_warm",   mk(1,0,0,0,0,2'd1,6'd0,0,0,0,1));
        push(85, "s4_pa24",   mk(1,0,0,1,0,2'd1,6'd0,0,0,0,1));
        push(86, "s4_txstart",mk(1,0,0,1,0,2'd1,6'd0,1,1,0,1));
        push(87, "s4_on",     mk(1,0,0,1,0,2'd1,6'd0,0,1,0,1));
        push(89, "s4_reset",  mk(0,0,0,0,0,2'd0,6'd0,0,0,0,0));
        go_at(88);
        @(posedge clk);
        #1 rst_n = 1'b0;
        go_at(91);
        rst_n = 1'b1;
        push(92,  "s5_warm",   mk(1,0,0,0,0,2'd1,6'd0,0,0,0,1));
        push(96,  "s5_pa24",   mk(1,0,0,1,0,2'd1,6'd0,0,0,0,1));
        push(97,  "s5_txstart",mk(1,0,0,1,0,2'd1,6'd0,1,1,0,1));
        push(98,  "s5_on",     mk(1,0,0,1,0,2'd1,6'd0,0,1,0,1));
        go_at(99);
        tx_req = 1'b0;
        push(100, "s5_down",   mk(1,0,0,0,0,2'd1,6'd0,0,0,0,1));
        push(103, "s5_guard",  mk(0,0,0,0,0,2'd1,6'd0,0,0,0,1));
        push(107, "s5_idle",   mk(0,0,0,0,0,2'd1,6'd0,0,0,0,0));

        while (exp_q.size() != 0 && cyc < 200) @(negedge clk);
        go_at(cyc + 5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected transitions never observed (next %s at cycle %0d)",
                     exp_q.size(), exp_q[0].name, exp_q[0].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
